// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// serial_add_ctrl : bit-serial a + b + cin adder, one full-adder stage, IDLE/RUN/DONE FSM
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_load;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_sbit;
  logic             w_cnext;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_next;

  assign w_sbit  = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cnext = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last  = (r_cnt == C_LAST);

  // Sum bits enter from the MSB end so the word is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_psum_next = w_sbit;
    end else begin : g_wn
      assign w_psum_next = {w_sbit, r_psum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_psum <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (w_load) begin
      r_a    <= a;
      r_b    <= b;
      r_c    <= cin;
      r_psum <= '0;
      r_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_c    <= w_cnext;
      r_psum <= w_psum_next;
      r_cnt  <= r_cnt + CW'(1);
      // Outputs only change on the final bit, so partial sums stay hidden.
      if (w_last) begin
        sum  <= w_psum_next;
        cout <= w_cnext;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range WIDTH >= 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH bits: operand A.
REQ-006 SHALL have port b, input, WIDTH bits: operand B.
REQ-007 SHALL have port cin, input, 1 bit: carry-in.
REQ-008 SHALL have port busy, output, 1 bit: addition in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL compute a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder stage (sum bit = x^y^c, carry = majority(x,y,c)).
REQ-014 SHALL accept start only in IDLE or DONE: at that edge, capture a and b into shift registers, load the carry register with cin, clear the bit counter, and enter RUN.
REQ-015 SHALL ignore start, a, b and cin while in RUN; no queuing.
REQ-016 SHALL, on each RUN edge, add the operand LSBs and the carry register, shift the sum bit into the partial-sum register from the MSB end, update the carry register, shift both operands right by one, and increment the counter.
REQ-017 SHALL, on the RUN edge that processes bit WIDTH-1, load sum with the completed partial sum, load cout with the final carry, and enter DONE.
REQ-018 SHALL give a latency of exactly WIDTH cycles: start accepted at edge k -> done high from edge k+WIDTH to edge k+WIDTH+1.
REQ-019 SHALL drive busy high exactly while in RUN, which is WIDTH cycles per operation.
REQ-020 SHALL drive done high exactly while in DONE, which is one cycle.
REQ-021 SHALL leave DONE after one cycle: to RUN if start is high (a new operation is accepted), otherwise to IDLE.
REQ-022 SHALL give back-to-back operations under continuously high start a period of WIDTH+1 cycles.
REQ-023 SHALL hold sum and cout constant from one completion until the next completion; partial results are never visible on sum or cout.
REQ-024 SHALL, for WIDTH=1, complete in one RUN cycle with the identical protocol.
REQ-025 SHALL size the counter to clog2(WIDTH)+1 bits with no wrap before termination.

Reset
REQ-026 SHALL, while rst is high, force IDLE and set busy=0, done=0, sum=0, cout=0, carry, counter and shift registers to 0, independent of clk.
REQ-027 SHALL, on rst asserted mid-RUN, abandon the operation with no done pulse and no update of sum or cout beyond the reset value.
REQ-028 SHALL accept start on the first rising clk edge after rst deasserts.

Verification
REQ-029 SHALL cover: assert rst -> immediately busy=0, done=0, sum=8'h00, cout=0.
REQ-030 SHALL cover, with WIDTH=8: a=8'h0F, b=8'h01, cin=0, one-cycle start -> busy high 8 cycles, then done for 1 cycle with sum=8'h10, cout=0.
REQ-031 SHALL cover carry propagation: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 SHALL cover start during RUN: start a=8'h03, b=8'h04, then pulse start with a=8'hAA, b=8'h55 at bit 3 -> single done, sum=8'h07, cout=0.
REQ-033 SHALL cover reset mid-RUN: rst high at bit 4 of a=8'h80, b=8'h80 -> busy=0 at once, no done, sum=8'h00, cout=0; a following start with the same operands -> sum=8'h00, cout=1.
REQ-034 SHALL cover continuous start: start held high over three operations -> done pulses exactly 9 cycles apart, each result correct.
